// File: rtl/dr_sweep_controller.sv
// Dynamic-range sweep controller: steps the sine amplitude through STEPS levels and reports
// peak |filt_out| and overflow count per level. Optional impulse pre-step: DR_SWEEP_IMPULSE_EN.
module dr_sweep_controller #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    OUT_WIDTH  = 32,
    parameter int                    STEPS      = 10,
    parameter int                    SETTLE     = 64,
    parameter int                    DWELL      = 480,
    parameter logic [DATA_WIDTH-1:0] AMP_MAX    = 16'hFFFF,
    parameter logic [OUT_WIDTH-1:0]  OVF_THRESH = {2'b00, {(OUT_WIDTH-2){1'b1}}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        sample_en,
    input  logic signed [OUT_WIDTH-1:0] filt_out,
    output logic [DATA_WIDTH-1:0]       amplitude,
    output logic                        busy,
    output logic                        done,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [7:0]                  res_step,
    output logic [OUT_WIDTH-1:0]        res_peak,
    output logic [15:0]                 res_ovf
);

    localparam logic [DATA_WIDTH-1:0] AMP_STEP = AMP_MAX / DATA_WIDTH'(STEPS);
    localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);
    localparam logic [7:0]       LAST_STEP   = 8'(STEPS - 1);

`ifdef DR_SWEEP_IMPULSE_EN
    localparam logic [7:0] IMPULSE_STEP = 8'hFF;
    typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_REPORT, ST_IMPULSE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_REPORT} state_t;
`endif

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] mag;
    logic                 last_step, handshake;
    logic                 busy_d, valid_d, done_d;

    // Two's-complement negate of the most negative input yields 2^(OUT_WIDTH-1), exact as unsigned.
    assign mag       = filt_out[OUT_WIDTH-1] ? (~$unsigned(filt_out) + 1'b1) : $unsigned(filt_out);
    assign last_step = (res_step == LAST_STEP);
    assign handshake = (state == ST_REPORT) && res_ready && !abort;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= busy_d;
            res_valid <= valid_d;
            done      <= done_d;
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef DR_SWEEP_IMPULSE_EN
                    if (start) next_state = ST_IMPULSE;
`else
                    if (start) next_state = ST_SETTLE;
`endif
                end
                ST_SETTLE:  if (sample_en && cnt == SETTLE_LAST) next_state = ST_MEASURE;
                ST_MEASURE: if (sample_en && cnt == DWELL_LAST)  next_state = ST_REPORT;
                ST_REPORT:  if (res_ready) next_state = last_step ? ST_IDLE : ST_SETTLE;
`ifdef DR_SWEEP_IMPULSE_EN
                ST_IMPULSE: if (sample_en) next_state = ST_MEASURE;
`endif
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d  = (next_state != ST_IDLE);
        valid_d = (next_state == ST_REPORT);
        done_d  = handshake && last_step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amplitude <= '0;
            cnt       <= '0;
            res_step  <= '0;
            res_peak  <= '0;
            res_ovf   <= '0;
        end else if (abort) begin
            amplitude <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        res_peak <= '0;
                        res_ovf  <= '0;
`ifdef DR_SWEEP_IMPULSE_EN
                        res_step  <= IMPULSE_STEP;
                        amplitude <= AMP_MAX;
`else
                        res_step  <= '0;
                        amplitude <= '0;
`endif
                    end
                end
`ifdef DR_SWEEP_IMPULSE_EN
                ST_IMPULSE: begin
                    if (sample_en) begin
                        amplitude <= '0;
                        cnt       <= '0;
                    end
                end
`endif
                ST_SETTLE: begin
                    if (sample_en) cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                end
                ST_MEASURE: begin
                    if (sample_en) begin
                        cnt <= (cnt == DWELL_LAST) ? '0 : cnt + 1'b1;
                        if (mag > res_peak) res_peak <= mag;
                        if (mag > OVF_THRESH && res_ovf != 16'hFFFF) res_ovf <= res_ovf + 16'd1;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        if (last_step) begin
                            amplitude <= '0;
                        end else begin
                            res_step <= res_step + 8'd1;
                            res_peak <= '0;
                            res_ovf  <= '0;
                            cnt      <= '0;
`ifdef DR_SWEEP_IMPULSE_EN
                            // The impulse record wraps the step index from 8'hFF to step 0.
                            amplitude <= (res_step == IMPULSE_STEP) ? '0 : amplitude + AMP_STEP;
`else
                            amplitude <= amplitude + AMP_STEP;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dr_sweep_controller.sv
// Randomized self-checking bench for dr_sweep_controller; expected records come from a
// per-step arithmetic model of the measured strobe values.
module tb_dr_sweep_controller;

    localparam int    STEPS      = 10;
    localparam int    SETTLE     = 64;
    localparam int    DWELL      = 480;
    localparam int    AMP_STEP   = 65535 / STEPS;
    localparam longint OVF_THRESH = (longint'(1) << 30) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               sample_en = 1'b0;
    logic signed [31:0] filt_out = '0;
    logic               res_ready = 1'b1;
    logic [15:0]        amplitude;
    logic               busy, done, res_valid;
    logic [7:0]         res_step;
    logic [31:0]        res_peak;
    logic [15:0]        res_ovf;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int hs_cnt = 0;

    dr_sweep_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_en(sample_en),
        .filt_out(filt_out), .amplitude(amplitude), .busy(busy), .done(done),
        .res_valid(res_valid), .res_ready(res_ready), .res_step(res_step),
        .res_peak(res_peak), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (res_valid && res_ready && !abort) hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic strobe(input logic [31:0] v);
        sample_en = 1'b1;
        filt_out  = v;
        tick();
        sample_en = 1'b0;
        filt_out  = $urandom;
    endtask

    function automatic logic [31:0] gen_val(input int mode, input logic [15:0] amp);
        int r;
        if (mode == 0) return {16'h0, amp};
        if (mode == 2) return 32'h8000_0000;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 32'h8000_0000;
            1:       return 32'h3FFF_FFFF;
            2:       return 32'h4000_0000;
            3:       return 32'hC000_0000;
            4:       return 32'hC000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_amplitude", amplitude, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", res_valid, 0);
        check("rst_step", res_step, 0);
        check("rst_peak", res_peak, 0);
        check("rst_ovf", res_ovf, 0);
        tick();
        rst = 1'b1;
        tick();
        check("rst_idle_busy", busy, 0);
    endtask

    task automatic do_abort();
        int d0;
        d0 = done_cnt;
        abort = 1'b1;
        start = 1'b1;
        sample_en = 1'b1;
        filt_out = 32'h8000_0000;
        tick();
        abort = 1'b0;
        start = 1'b0;
        sample_en = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_amplitude", amplitude, 0);
        check("abort_valid", res_valid, 0);
        repeat (5) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_stays_idle", busy, 0);
    endtask

    task automatic do_step(input int mode, input int k, input bit impulse, input bit stall,
                           input bit abort_here, input bit reset_here, output bit stop);
        logic [31:0] v;
        logic [7:0]  sid;
        logic [15:0] amp;
        longint      sv, m, pk, ov;
        stop = 1'b0;
        sid  = impulse ? 8'hFF : 8'(k);
        amp  = impulse ? 16'h0 : 16'(k * AMP_STEP);
        if (impulse) begin
            check("impulse_amp", amplitude, 16'hFFFF);
            gap();
            check("impulse_amp_hold", amplitude, 16'hFFFF);
            strobe($urandom);
            check("impulse_amp_off", amplitude, 0);
        end else begin
            check("step_amp", amplitude, amp);
            for (int i = 0; i < SETTLE; i++) begin
                gap();
                if (reset_here && i == SETTLE / 2) begin
                    apply_reset();
                    stop = 1'b1;
                    return;
                end
                strobe($urandom);
            end
        end
        check("busy_measure", busy, 1);
        pk = 0;
        ov = 0;
        for (int i = 0; i < DWELL; i++) begin
            gap();
            if (abort_here && i == DWELL / 2) begin
                do_abort();
                stop = 1'b1;
                return;
            end
            v = gen_val(mode, amp);
            strobe(v);
            sv = longint'($signed(v));
            m  = (sv < 0) ? -sv : sv;
            if (m > pk) pk = m;
            if (m > OVF_THRESH) ov++;
            if (i == DWELL / 2) check("no_early_valid", res_valid, 0);
        end
        if (ov > 65535) ov = 65535;
        check("res_valid", res_valid, 1);
        check("res_step", res_step, sid);
        check("res_peak", res_peak, pk);
        check("res_ovf", res_ovf, ov);
        check("report_amp", amplitude, amp);
        if (stall) begin
            res_ready = 1'b0;
            repeat (50) begin
                sample_en = 1'($urandom_range(0, 1));
                filt_out  = 32'h8000_0000;
                tick();
                check("stall_valid", res_valid, 1);
                check("stall_step", res_step, sid);
                check("stall_peak", res_peak, pk);
                check("stall_ovf", res_ovf, ov);
                check("stall_amp", amplitude, amp);
            end
            res_ready = 1'b1;
        end
        sample_en = 1'($urandom_range(0, 1));
        filt_out  = 32'h8000_0000;
        tick();
        sample_en = 1'b0;
        check("valid_drop", res_valid, 0);
        if (!impulse && k == STEPS - 1) begin
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_amp", amplitude, 0);
            tick();
            check("done_one_cycle", done, 0);
        end else begin
            check("next_busy", busy, 1);
            check("next_no_done", done, 0);
        end
    endtask

    task automatic run_sweep(input int mode, input int stall_k, input int abort_k, input int reset_k);
        bit stop;
        int d0, h0, nrec;
        d0 = done_cnt;
        h0 = hs_cnt;
        nrec = STEPS;
        start = 1'b1;
        tick();
        check("start_busy", busy, 1);
        tick();
        start = 1'b0;
`ifdef DR_SWEEP_IMPULSE_EN
        nrec = STEPS + 1;
        do_step(mode, 0, 1'b1, 1'b0, 1'b0, 1'b0, stop);
`endif
        for (int k = 0; k < STEPS; k++) begin
            do_step(mode, k, 1'b0, k == stall_k, k == abort_k, k == reset_k, stop);
            if (stop) return;
        end
        check("done_once", done_cnt - d0, 1);
        check("record_count", hs_cnt - h0, nrec);
        repeat (3) tick();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_amplitude", amplitude, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_valid", res_valid, 0);
        check("init_step", res_step, 0);
        check("init_peak", res_peak, 0);
        check("init_ovf", res_ovf, 0);
        rst = 1'b1;
        tick();
        run_sweep(0, 3, -1, -1);
        run_sweep(2, -1, -1, -1);
        run_sweep(1, -1, 5, -1);
        run_sweep(1, -1, -1, -1);
        run_sweep(1, -1, -1, 2);
        run_sweep(0, -1, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
